fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001: Parameter DATASIZE, default 8, width of each write data word; matches the FIFO DATASIZE.
- REQ-002: Parameter NREQ, default 4, number of write requesters; legal range 2..8.
- REQ-003: Parameter BURST, default 4, maximum words accepted per grant; legal range 1..16.
- REQ-004: wclk_i  input  1  write-domain clock; the only clock; all state changes on its rising edge.
- REQ-005: wrst_i  input  1  reset; synchronous, active-high.
- REQ-006: req_i  input  NREQ  per-requester write request; bit k belongs to requester k.
- REQ-007: data_i  input  NREQ*DATASIZE  per-requester write data; requester k occupies bits [k*DATASIZE +: DATASIZE].
- REQ-008: fifo_full_i  input  1  FIFO full flag, already in the wclk_i domain.
- REQ-009: gnt_o  output  NREQ  registered one-hot grant; all zero when no requester owns the port.
- REQ-010: ack_o  output  NREQ  per-requester word-accepted strobe.
- REQ-011: fifo_wen_o  output  1  FIFO write enable.
- REQ-012: fifo_din_o  output  DATASIZE  FIFO write data.
- REQ-013: owner_o  output  $clog2(NREQ)  index of the current or last grantee.
- REQ-014: busy_o  output  1  high in GRANT and STALL.
- REQ-015: cnt_o  output  NREQ*16  per-requester accepted-word counters; see Configuration.

Function
- REQ-016: FSM states are IDLE, GRANT and STALL.
- REQ-017: IDLE with any req_i bit set: select the first set bit searching round-robin from (owner_o+1) mod NREQ, load gnt_o and owner_o, clear the burst counter, and go to GRANT. Grant appears one cycle after req_i.
- REQ-018: An accept occurs in a GRANT cycle when req_i[owner_o]=1 and fifo_full_i=0.
- REQ-019: On an accept, fifo_wen_o, ack_o[owner_o] and the burst counter increment all occur in that same cycle; fifo_wen_o and ack_o are combinational from state, req_i and fifo_full_i.
- REQ-020: fifo_din_o = data_i slice of owner_o at all times; fifo_wen_o is never high while fifo_full_i=1.
- REQ-021: The requester presents its next word in the cycle after ack_o.
- REQ-022: GRANT -> IDLE with gnt_o cleared when the accept brings the burst count to BURST, or when req_i[owner_o]=0.
- REQ-023: GRANT -> STALL when fifo_full_i=1 and req_i[owner_o]=1; gnt_o and the burst count are held.
- REQ-024: STALL -> GRANT when fifo_full_i=0; STALL -> IDLE when req_i[owner_o] drops.
- REQ-025: IDLE always costs one dead cycle between grants; maximum throughput is BURST words per BURST+1 cycles.
- REQ-026: Requests from non-owners are ignored until the FSM returns to IDLE.
- REQ-027: Round-robin guarantees that each continuously requesting requester is granted within NREQ arbitration rounds.

Reset
- REQ-028: While wrst_i=1 at a rising edge: state=IDLE, gnt_o=0, owner_o=NREQ-1 (so requester 0 has first priority), burst count=0, cnt_o=0.
- REQ-029: fifo_wen_o and ack_o are 0 while wrst_i=1.
- REQ-030: Reset asserted mid-burst aborts the burst; no write occurs in the reset cycle.

Configuration
- REQ-031: Macro ARB_STATS_EN. When defined, each cnt_o slice increments on its requester's accept and saturates at 16'hFFFF.
- REQ-032: When ARB_STATS_EN is not defined, cnt_o is tied to 0 and no counter flops exist.

Verification
- REQ-033: Reset, then req_i=4'b0001 with data 8'h10..8'h13 -> gnt_o=0001 one cycle later; four consecutive ack_o[0]; FIFO receives 10,11,12,13; IDLE on the fifth cycle.
- REQ-034: req_i=4'b1111 held continuously, BURST=4 -> grants in order 0,1,2,3,0; each grant gets 4 words; one dead cycle between grants.
- REQ-035: Owner mid-burst, fifo_full_i high for 3 cycles -> STALL; fifo_wen_o=0 for those 3 cycles; resumes with the same word and no loss or duplicate; burst totals 4.
- REQ-036: Owner drops req after 2 words -> IDLE next cycle; the next requester round-robin after the owner is granted.
- REQ-037: wrst_i pulsed during GRANT after 2 words -> all outputs clear; the next grant goes to requester 0.
- REQ-038: With ARB_STATS_EN defined, 20 words from requester 2 -> cnt_o slice 2 = 20 and all other slices 0. Without the macro -> cnt_o=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited write arbiter in front of a FIFO write port.
// Define ARB_STATS_EN to build per-requester saturating accept counters.
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int BURST    = 4
) (
  input  logic                       wclk_i,
  input  logic                       wrst_i,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*DATASIZE-1:0]   data_i,
  input  logic                       fifo_full_i,
  output logic [NREQ-1:0]            gnt_o,
  output logic [NREQ-1:0]            ack_o,
  output logic                       fifo_wen_o,
  output logic [DATASIZE-1:0]        fifo_din_o,
  output logic [$clog2(NREQ)-1:0]    owner_o,
  output logic                       busy_o,
  output logic [NREQ*16-1:0]         cnt_o
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STALL
  } state_t;

  state_t        state;
  logic [4:0]    burst;
  logic [OW-1:0] nxt;
  logic          own_req;
  logic          accept;
  logic          last;

  assign own_req    = req_i[owner_o];
  assign accept     = (state == GRANT) & own_req
                    & ~fifo_full_i & ~wrst_i;
  assign last       = (burst == 5'(BURST - 1));
  assign fifo_wen_o = accept;
  assign fifo_din_o = data_i[owner_o*DATASIZE +: DATASIZE];
  assign busy_o     = (state != IDLE);

  always_comb begin
    ack_o          = '0;
    ack_o[owner_o] = accept;
  end

  // First requester after the last owner, wrapping around.
  always_comb begin
    logic found;
    nxt   = owner_o;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req_i[(int'(owner_o) + i) % NREQ]) begin
        nxt   = OW'((int'(owner_o) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      state   <= IDLE;
      gnt_o   <= '0;
      owner_o <= OW'(NREQ - 1);
      burst   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            state   <= GRANT;
            owner_o <= nxt;
            gnt_o   <= NREQ'(1) << nxt;
            burst   <= '0;
          end
        end
        GRANT: begin
          if (!own_req) begin
            state <= IDLE;
            gnt_o <= '0;
          end else if (fifo_full_i) begin
            state <= STALL;
          end else begin
            burst <= burst + 5'd1;
            if (last) begin
              state <= IDLE;
              gnt_o <= '0;
            end
          end
        end
        STALL: begin
          if (!own_req) begin
            state <= IDLE;
            gnt_o <= '0;
          end else if (!fifo_full_i) begin
            state <= GRANT;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge wclk_i) begin
      if (wrst_i) begin
        cnt <= '0;
      end else if (ack_o[k] && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign cnt_o[k*16 +: 16] = cnt;
  end
`else
  assign cnt_o = '0;
`endif

endmodule
